// File: rtl/axis_pkg.sv
// Shared types and helpers for the AXI-Stream digest transmitter.
// Provides default widths, the FSM state type and the TKEEP mask builder.
package axis_pkg;
  localparam int DATA_W_DEF  = 16;
  localparam int STATE_W_DEF = 256;
  localparam int KEEP_MAX    = 64;

  typedef enum logic {IDLE, SEND} state_t;

  // rem == 0 means the final beat is full, so all kb low bits are set.
  function automatic logic [KEEP_MAX-1:0] keep_for_bytes(input int unsigned rem,
                                                         input int unsigned kb = DATA_W_DEF/8);
    logic [KEEP_MAX-1:0] m;
    m = '0;
    for (int unsigned i = 0; i < KEEP_MAX; i++)
      if ((rem == 0 && i < kb) || i < rem) m[i] = 1'b1;
    return m;
  endfunction
endpackage

// File: rtl/axis_beat_counter.sv
// Beat counter for one packet: loaded with the beat count, stepped per handshake.
// Flags the current beat as final and predicts whether the next beat will be.
module axis_beat_counter #(
  parameter int CW = 5
) (
  input  logic          ACLK,
  input  logic          ARESET,
  input  logic          i_load,
  input  logic [CW-1:0] i_n,
  input  logic          i_inc,
  output logic          o_is_last,
  output logic          o_next_last
);
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] r_n;

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      r_cnt <= '0;
      r_n   <= '0;
    end else if (i_load) begin
      r_cnt <= '0;
      r_n   <= i_n;
    end else if (i_inc) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // One extra bit so cnt+2 cannot wrap on the largest beat count.
  assign o_is_last   = ((CW+1)'(r_cnt) + (CW+1)'(1)) == (CW+1)'(r_n);
  assign o_next_last = ((CW+1)'(r_cnt) + (CW+1)'(2)) == (CW+1)'(r_n);
endmodule

// File: rtl/axis_digest_transmitter.sv
// AXI-Stream master serialising a wide digest word into DATA_W beats, little-endian,
// with TUSER on the first beat, TLAST on the last and TKEEP trimming a partial last beat.
module axis_digest_transmitter
  import axis_pkg::*;
#(
  parameter int         DATA_W    = DATA_W_DEF,
  parameter int         STATE_W   = STATE_W_DEF,
  parameter logic [7:0] TID_VAL   = 8'h00,
  parameter logic       TDEST_VAL = 1'b0
) (
  input  logic                         ACLK,
  input  logic                         ARESET,
  input  logic                         load,
  input  logic [STATE_W-1:0]           in_state,
  input  logic [$clog2(STATE_W/8):0]   in_bytes,
  output logic                         busy,
  output logic                         done,
  output logic                         TVALID,
  input  logic                         TREADY,
  output logic [DATA_W-1:0]            TDATA,
  output logic [DATA_W/8-1:0]          TKEEP,
  output logic [DATA_W/8-1:0]          TSTRB,
  output logic [7:0]                   TID,
  output logic                         TDEST,
  output logic                         TUSER,
  output logic                         TLAST
);
  localparam int KB     = DATA_W/8;
  localparam int NB     = STATE_W/8;
  localparam int BW     = $clog2(NB) + 1;
  localparam int NBEATS = STATE_W/DATA_W;
  localparam int CW     = $clog2(NBEATS + 1);

  state_t               r_state;
  logic [STATE_W-1:0]   r_shift;
  logic [KB-1:0]        r_keep;
  logic [KB-1:0]        r_last_keep;
  logic                 r_valid, r_last, r_user, r_busy, r_done;

  logic [BW-1:0]        w_bytes;
  logic [CW-1:0]        w_nbeats;
  logic [KB-1:0]        w_last_keep;
  logic                 w_accept, w_hs, w_is_last, w_next_last;

  always_comb begin
    w_bytes     = (in_bytes > BW'(NB)) ? BW'(NB) : in_bytes;
    w_nbeats    = CW'((32'(w_bytes) + KB - 1) / KB);
    w_last_keep = KB'(keep_for_bytes(32'(w_bytes) % KB, KB));
  end

  assign w_accept = (r_state == IDLE) && load && (in_bytes != '0);
  assign w_hs     = (r_state == SEND) && r_valid && TREADY;

  axis_beat_counter #(.CW(CW)) u_cnt (
    .ACLK        (ACLK),
    .ARESET      (ARESET),
    .i_load      (w_accept),
    .i_n         (w_nbeats),
    .i_inc       (w_hs),
    .o_is_last   (w_is_last),
    .o_next_last (w_next_last)
  );

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      r_state     <= IDLE;
      r_shift     <= '0;
      r_keep      <= '0;
      r_last_keep <= '0;
      r_valid     <= 1'b0;
      r_last      <= 1'b0;
      r_user      <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_state     <= SEND;
            r_shift     <= in_state;
            r_last_keep <= w_last_keep;
            r_keep      <= (w_nbeats == CW'(1)) ? w_last_keep : '1;
            r_last      <= (w_nbeats == CW'(1));
            r_user      <= 1'b1;
            r_valid     <= 1'b1;
            r_busy      <= 1'b1;
          end
        end
        SEND: begin
          if (w_hs) begin
            if (w_is_last) begin
              r_state <= IDLE;
              r_valid <= 1'b0;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_last  <= 1'b0;
              r_user  <= 1'b0;
            end else begin
              r_shift <= r_shift >> DATA_W;
              r_user  <= 1'b0;
              r_last  <= w_next_last;
              r_keep  <= w_next_last ? r_last_keep : '1;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign TVALID = r_valid;
  assign TDATA  = r_shift[DATA_W-1:0];
  assign TKEEP  = r_keep;
  assign TSTRB  = r_keep;
  assign TLAST  = r_last;
  assign TUSER  = r_user;
  assign TID    = TID_VAL;
  assign TDEST  = TDEST_VAL;
  assign busy   = r_busy;
  assign done   = r_done;
endmodule

// File: tb/tb_axis_digest_transmitter.sv
// Scoreboard bench for axis_digest_transmitter: expected beats are queued at load
// and checked at every handshake, with stall-stability and control checks.
module tb_axis_digest_transmitter;
  logic         ACLK = 1'b0;
  logic         ARESET;
  logic         load;
  logic [255:0] in_state;
  logic [5:0]   in_bytes;
  logic         busy, done, TVALID, TREADY, TDEST, TUSER, TLAST;
  logic [15:0]  TDATA;
  logic [1:0]   TKEEP, TSTRB;
  logic [7:0]   TID;

  typedef struct packed {
    logic [15:0] data;
    logic [1:0]  keep;
    logic        user;
    logic        last;
  } beat_t;

  beat_t sb[$];
  int n_chk = 0, n_err = 0;
  int n_done = 0, n_xfer = 0, cyc = 0;
  int mode = 2;
  bit saw_valid = 0, stall_prev = 0;
  beat_t held;

  axis_digest_transmitter dut (
    .ACLK(ACLK), .ARESET(ARESET), .load(load), .in_state(in_state), .in_bytes(in_bytes),
    .busy(busy), .done(done), .TVALID(TVALID), .TREADY(TREADY), .TDATA(TDATA),
    .TKEEP(TKEEP), .TSTRB(TSTRB), .TID(TID), .TDEST(TDEST), .TUSER(TUSER), .TLAST(TLAST)
  );

  always #5 ACLK = ~ACLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s got %0h exp %0h", tag, obs, exp);
    end
  endtask

  // mode 0: always ready, 1: ready on every third cycle, 2: driven by the test
  always @(posedge ACLK) begin
    #1;
    cyc++;
    if (mode == 0) TREADY = 1'b1;
    else if (mode == 1) TREADY = (cyc % 3 == 0);
  end

  always @(negedge ACLK) begin
    if (ARESET) begin
      stall_prev = 0;
    end else begin
      if (TVALID) saw_valid = 1;
      if (done) n_done++;
      if (stall_prev && TVALID) begin
        chk("hold_data", TDATA, held.data);
        chk("hold_last", TLAST, held.last);
      end
      if (TVALID && TREADY) begin
        n_xfer++;
        if (sb.size() == 0) chk("extra_beat", 1, 0);
        else begin
          beat_t e;
          e = sb.pop_front();
          chk("tdata", TDATA, e.data);
          chk("tkeep", TKEEP, e.keep);
          chk("tuser", TUSER, e.user);
          chk("tlast", TLAST, e.last);
          chk("tstrb", TSTRB, TKEEP);
          chk("tid", TID, 8'h00);
          chk("tdest", TDEST, 1'b0);
        end
      end
      stall_prev = TVALID && !TREADY;
      held = '{TDATA, TKEEP, TUSER, TLAST};
    end
  end

  task automatic push_pkt(input logic [255:0] st, input int bytes);
    int nb, n;
    nb = (bytes > 32) ? 32 : bytes;
    n  = (nb + 1) / 2;
    for (int j = 0; j < n; j++)
      sb.push_back('{st[16*j +: 16], (j == n-1 && nb % 2 == 1) ? 2'b01 : 2'b11, j == 0, j == n-1});
  endtask

  task automatic do_load(input logic [255:0] st, input int bytes);
    in_state = st;
    in_bytes = 6'(bytes);
    load = 1'b1;
    @(posedge ACLK); #1;
    load = 1'b0;
    in_state = '1;
    in_bytes = '0;
  endtask

  task automatic wait_done();
    int k;
    for (k = 0; k < 200; k++) begin
      if (done) break;
      @(posedge ACLK); #1;
    end
    if (k == 200) chk("done_timeout", 0, 1);
  endtask

  task automatic run_pkt(input logic [255:0] st, input int bytes, input int beats);
    int d0, x0;
    d0 = n_done;
    x0 = n_xfer;
    push_pkt(st, bytes);
    do_load(st, bytes);
    chk("lat_valid", TVALID, 1);
    chk("lat_busy", busy, 1);
    wait_done();
    chk("done_busy", busy, 0);
    chk("done_valid", TVALID, 0);
    @(posedge ACLK); #1;
    chk("done_width", done, 0);
    chk("done_count", n_done - d0, 1);
    chk("xfer_count", n_xfer - x0, beats);
    chk("q_empty", sb.size(), 0);
  endtask

  logic [255:0] seq, ra, rb, rc;
  int d0, x0, k;

  initial begin
    for (int i = 0; i < 32; i++) seq[8*i +: 8] = 8'(i);
    ra = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    rb = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    rc = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    ARESET = 1'b1; load = 1'b0; TREADY = 1'b0; in_state = '0; in_bytes = '0;
    repeat (3) @(posedge ACLK);
    #1;
    chk("rst_valid", TVALID, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_data", TDATA, 0);
    chk("rst_keep", TKEEP, 0);
    chk("rst_strb", TSTRB, 0);
    chk("rst_last", TLAST, 0);
    chk("rst_user", TUSER, 0);
    ARESET = 1'b0;
    mode = 0;
    repeat (2) @(posedge ACLK);
    #1;

    run_pkt(seq, 32, 16);
    mode = 1;
    run_pkt(seq, 32, 16);
    mode = 0;
    run_pkt(seq, 27, 14);
    run_pkt(seq, 1, 1);
    run_pkt(ra, 40, 16);
    mode = 1;
    run_pkt(rb, 5, 3);
    run_pkt(rc, 27, 14);

    // zero byte count must be ignored
    mode = 0;
    d0 = n_done;
    saw_valid = 0;
    do_load(seq, 0);
    repeat (5) @(posedge ACLK);
    #1;
    chk("zero_valid", saw_valid, 0);
    chk("zero_done", n_done - d0, 0);
    chk("zero_busy", busy, 0);

    // reset in the middle of a stalled packet
    mode = 2;
    TREADY = 1'b1;
    x0 = n_xfer;
    push_pkt(seq, 32);
    do_load(seq, 32);
    for (k = 0; k < 50; k++) begin
      if (n_xfer - x0 == 6) break;
      @(posedge ACLK); #1;
    end
    if (k == 50) chk("rst_wait", 0, 1);
    TREADY = 1'b0;
    @(posedge ACLK); #1;
    chk("stall_valid", TVALID, 1);
    ARESET = 1'b1;
    @(posedge ACLK); #1;
    chk("midrst_valid", TVALID, 0);
    chk("midrst_busy", busy, 0);
    ARESET = 1'b0;
    chk("midrst_left", sb.size(), 10);
    sb.delete();
    mode = 0;
    @(posedge ACLK); #1;
    run_pkt(ra, 32, 16);

    // load while busy is dropped; load in the done cycle is taken
    d0 = n_done;
    x0 = n_xfer;
    push_pkt(rb, 32);
    do_load(rb, 32);
    repeat (3) @(posedge ACLK);
    #1;
    do_load(rc, 4);
    wait_done();
    push_pkt(rc, 6);
    do_load(rc, 6);
    chk("b2b_valid", TVALID, 1);
    chk("b2b_user", TUSER, 1);
    wait_done();
    @(posedge ACLK); #1;
    chk("b2b_done", n_done - d0, 2);
    chk("b2b_xfer", n_xfer - x0, 19);
    chk("b2b_q", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/axis_digest_transmitter.md
Name: axis_digest_transmitter

Overview:
AXI-Stream master that serialises a wide SHA3 state/digest word into DATA_W-bit beats with TLAST on the final beat. It is the transmit end of the stream interface consumed by Axi_Stream_Receiver, and sits between the Keccak core output and the downstream stream sink. It supports truncated digests (e.g. SHA3-224/256) via a byte count, with TKEEP/TSTRB marking a partial final beat.

Parameters:
DATA_W, 16, TDATA width in bits; must be a multiple of 8.
STATE_W, 256, width of in_state in bits; must be a multiple of DATA_W.
TID_VAL, 8'h00, constant driven on TID.
TDEST_VAL, 1'b0, constant driven on TDEST.

Ports:
ACLK  in  1  clock; all logic rising-edge.
ARESET  in  1  synchronous reset, active-high.
load  in  1  start request; sampled only in IDLE.
in_state  in  STATE_W  data to send; captured on accepted load.
in_bytes  in  $clog2(STATE_W/8)+1  bytes to send; captured on accepted load.
busy  out  1  high from accepted load until final handshake.
done  out  1  one-cycle pulse after final handshake.
TVALID  out  1  AXIS valid.
TREADY  in  1  AXIS ready.
TDATA  out  DATA_W  AXIS data.
TKEEP  out  DATA_W/8  byte qualifiers.
TSTRB  out  DATA_W/8  always equal to TKEEP.
TID  out  8  = TID_VAL.
TDEST  out  1  = TDEST_VAL.
TUSER  out  1  high on first beat of a packet only.
TLAST  out  1  high on final beat only.

Behaviour:
- Reset (ARESET high at edge): state IDLE; TVALID, TLAST, TUSER, busy, done = 0; TDATA, TKEEP, TSTRB = 0; shift register and beat counter cleared. Reset mid-packet abandons the packet; TVALID is low after that edge regardless of TREADY.
- Byte order: byte k = in_state[8k+7:8k]; beat j carries bytes j*DATA_W/8 upward, byte 0 in TDATA[7:0] (little-endian, matches Keccak lane order).
- in_bytes: value 0 -> load ignored (stays IDLE, no done). Values above STATE_W/8 are clamped to STATE_W/8. Beats N = ceil(bytes/(DATA_W/8)).
- States: IDLE, SEND.
- IDLE: TVALID=0, busy=0. On load=1 with legal in_bytes: capture in_state into shift register and compute N and final-beat keep; go to SEND. TVALID=1 in the next cycle (latency 1), with beat 0 on TDATA, TUSER=1, and TLAST=1 if N=1.
- SEND: TVALID=1. A beat transfers on an edge where TVALID&&TREADY. With no transfer, TDATA/TKEEP/TSTRB/TLAST/TUSER are held stable. On transfer of a non-final beat: shift register right by DATA_W, counter+1, TUSER=0, TLAST=1 on the next beat iff that beat is N-1. On transfer of the final beat: go to IDLE, TVALID=0 and busy=0 next cycle, done=1 for exactly that one cycle.
- TKEEP: all ones except the final beat, which has the low (bytes mod (DATA_W/8)) bits set when that value is nonzero. TSTRB = TKEEP.
- load while busy is ignored; in_state/in_bytes may change freely after capture.
- Back-to-back operation: load asserted in the done cycle (state is IDLE) is accepted, so there is a minimum one idle cycle between packets.
- TREADY high before TVALID has no effect; TVALID never depends combinationally on TREADY.

Decomposition:
- Shared package axis_pkg: DATA_W and STATE_W defaults, state enum typedef {IDLE, SEND}, and function keep_for_bytes(rem) returning the TKEEP mask.
- Optional sub-module axis_beat_counter (load N, increment on handshake, flag is_last); the rest stays flat.

Test Plan:
- Full 256-bit, TREADY=1 constant: in_state=256'h1F1E..0100 (byte k = k), in_bytes=32 -> 16 beats on consecutive cycles, TDATA 16'h0100, 16'h0302, ... 16'h1F1E; TKEEP=2'b11 throughout; TUSER only on beat 0, TLAST only on beat 15; done pulses once.
- Backpressure: same packet, TREADY toggling 1,0,0,1,... -> TDATA/TLAST held during stall cycles; exactly 16 transfers; no beat dropped or duplicated.
- Odd truncation: in_bytes=27 -> 14 beats; final TDATA[7:0]=8'h1A; TKEEP=TSTRB=2'b01, TLAST=1 on that beat.
- Edge counts: in_bytes=0 -> no TVALID, no done. in_bytes=1 -> single beat with TUSER=TLAST=1 and TKEEP=2'b01. in_bytes=40 -> clamped to 32, 16 beats.
- Reset mid-packet: ARESET high after beat 5 with TREADY=0 -> TVALID=0, busy=0 next cycle. A new load afterwards restarts at beat 0 with TUSER=1.
- Load during busy, then load in the done cycle: the first load is ignored; the second is accepted, TVALID rises 1 cycle later, and the new packet data is correct.
